// File: rtl/avalon_ram_slave.sv
// Avalon-MM word RAM slave with a programmable stall length and a side
// program-load port that writes whole words while the bus side is idle.
module avalon_ram_slave #(
    parameter int ADDR_WORDS_LOG2 = 10,
    parameter int WAIT_CYCLES     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] address,
    input  logic        read,
    input  logic        write,
    output logic        waitrequest,
    input  logic [31:0] writedata,
    input  logic [3:0]  byteenable,
    output logic [31:0] readdata,
    input  logic        inst_input,
    input  logic [7:0]  inst_addr,
    input  logic [31:0] instruction
);

    localparam int DEPTH = 1 << ADDR_WORDS_LOG2;
    localparam int CNT_W = (WAIT_CYCLES < 2) ? 1 : $clog2(WAIT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t                     state_reg, state_next;
    logic [CNT_W-1:0]           cnt_reg, cnt_next;
    logic [ADDR_WORDS_LOG2-1:0] idx_reg, bus_idx, load_idx, rd_idx;
    logic [31:0]                wdata_reg, readdata_reg, rd_word, load_full;
    logic [3:0]                 be_reg;
    logic                       write_reg;
    logic                       req, accept, wait_c, load_rd, commit, load_we;
    logic                       unused_ok;

    assign req       = read | write;
    assign bus_idx   = address[ADDR_WORDS_LOG2+1:2];
    assign load_full = {26'd0, inst_addr[7:2]};
    assign load_idx  = load_full[ADDR_WORDS_LOG2-1:0];
    assign unused_ok = ^{address, load_full, inst_addr[1:0]};

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        wait_c     = 1'b0;
        accept     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (req) begin
                    wait_c = 1'b1;
                    // A program load owns the memory; bus requests stall until it ends.
                    if (!inst_input) begin
                        accept     = 1'b1;
                        cnt_next   = CNT_W'(WAIT_CYCLES);
                        state_next = (WAIT_CYCLES > 0) ? WAIT : RESP;
                    end
                end
            end
            WAIT: begin
                wait_c = 1'b1;
                if (!req) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg - CNT_W'(1);
                    if (cnt_reg == CNT_W'(1))
                        state_next = RESP;
                end
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // From IDLE (zero-wait build) the word index is still on the bus, not yet latched.
    assign rd_idx  = (state_reg == IDLE) ? bus_idx : idx_reg;
    assign load_rd = (state_next == RESP) && ((state_reg == IDLE) ? !write : !write_reg);
    assign commit  = (state_reg == RESP) && write_reg && !reset;
    assign load_we = (state_reg == IDLE) && inst_input && !reset;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= IDLE;
            cnt_reg      <= '0;
            idx_reg      <= '0;
            wdata_reg    <= '0;
            be_reg       <= '0;
            write_reg    <= 1'b0;
            readdata_reg <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            if (accept) begin
                idx_reg   <= bus_idx;
                wdata_reg <= writedata;
                be_reg    <= byteenable;
                write_reg <= write;
            end
            if (load_rd)
                readdata_reg <= rd_word;
        end
    end

    // One byte-wide array per lane so byte enables map onto independent write ports.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] lane_mem [DEPTH];
            always_ff @(posedge clk) begin
                if (commit && be_reg[gi])
                    lane_mem[idx_reg] <= wdata_reg[8*gi +: 8];
                else if (load_we)
                    lane_mem[load_idx] <= instruction[8*gi +: 8];
            end
            assign rd_word[8*gi +: 8] = lane_mem[rd_idx];
        end
    endgenerate

    assign waitrequest = wait_c;
    assign readdata    = readdata_reg;

endmodule

// File: tb/tb_avalon_ram_slave.sv
// Bench for avalon_ram_slave: a WAIT_CYCLES=2 instance carries most traffic,
// a WAIT_CYCLES=0 instance covers the single-stall build.
module tb_avalon_ram_slave;

    localparam int WC = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] address [2];
    logic [31:0] writedata [2];
    logic [31:0] readdata [2];
    logic [3:0]  byteenable [2];
    logic        read [2];
    logic        write [2];
    logic        waitrequest [2];
    logic        inst_input [2];
    logic [7:0]  inst_addr;
    logic [31:0] instruction;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic [31:0] exp_q [$];
    logic [31:0] last_rd [2];

    typedef struct {
        bit          rd;
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [12];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    avalon_ram_slave #(.ADDR_WORDS_LOG2(10), .WAIT_CYCLES(WC)) dut (
        .clk(clk), .reset(reset), .address(address[0]), .read(read[0]), .write(write[0]),
        .waitrequest(waitrequest[0]), .writedata(writedata[0]), .byteenable(byteenable[0]),
        .readdata(readdata[0]), .inst_input(inst_input[0]), .inst_addr(inst_addr),
        .instruction(instruction)
    );

    avalon_ram_slave #(.ADDR_WORDS_LOG2(10), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .reset(reset), .address(address[1]), .read(read[1]), .write(write[1]),
        .waitrequest(waitrequest[1]), .writedata(writedata[1]), .byteenable(byteenable[1]),
        .readdata(readdata[1]), .inst_input(inst_input[1]), .inst_addr(inst_addr),
        .instruction(instruction)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drives one transfer, counts stall cycles and checks data during the completing cycle.
    task automatic xfer(input int d, input bit rd, input bit wr, input logic [31:0] a,
                        input logic [31:0] wd, input logic [3:0] be, input logic [31:0] exp,
                        input int exp_waits);
        int          waits;
        logic [31:0] e;
        @(negedge clk);
        address[d] = a; writedata[d] = wd; byteenable[d] = be; read[d] = rd; write[d] = wr;
        if (rd && !wr) exp_q.push_back(exp);
        waits = 0;
        #1;
        while (waitrequest[d] && waits < 60) begin
            waits++;
            @(negedge clk);
            #1;
        end
        if (waitrequest[d]) begin
            checks++;
            errors++;
            $display("FAIL timeout: dut%0d addr %h still stalled after %0d cycles", d, a, waits);
            read[d] = 1'b0;
            write[d] = 1'b0;
        end else begin
            check("waits", 32'(waits), 32'(exp_waits));
            if (rd && !wr) begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hx;
                check("rdata", readdata[d], e);
                last_rd[d] = e;
            end else begin
                check("rd_hold", readdata[d], last_rd[d]);
            end
            $display("xfer dut%0d %s addr=%h wdata=%h be=%h waits=%0d rdata=%h", d,
                     (rd && !wr) ? "RD" : "WR", a, wd, be, waits, readdata[d]);
            @(posedge clk);
        end
    endtask

    task automatic idle(input int d);
        @(negedge clk);
        read[d] = 1'b0;
        write[d] = 1'b0;
    endtask

    task automatic load_word(input logic [7:0] a, input logic [31:0] w);
        @(negedge clk);
        inst_input[0] = 1'b1; inst_addr = a; instruction = w;
        @(negedge clk);
        inst_input[0] = 1'b0;
    endtask

    initial begin
        int t0;
        vecs[0]  = '{0, 1, 32'h0000_0010, 32'hAABB_CCDD, 4'hF, 32'h0};
        vecs[1]  = '{0, 1, 32'h0000_0010, 32'h1122_3344, 4'h5, 32'h0};
        vecs[2]  = '{1, 0, 32'h0000_0010, 32'h0,         4'h0, 32'hAA22_CC44};
        vecs[3]  = '{0, 1, 32'h0000_1014, 32'hCAFE_BABE, 4'hF, 32'h0};
        vecs[4]  = '{1, 0, 32'h0000_0014, 32'h0,         4'h0, 32'hCAFE_BABE};
        vecs[5]  = '{1, 0, 32'hBFC0_0017, 32'h0,         4'h0, 32'hCAFE_BABE};
        vecs[6]  = '{1, 1, 32'h0000_0018, 32'h1234_5678, 4'hF, 32'h0};
        vecs[7]  = '{0, 1, 32'h0000_0008, 32'h5A5A_A5A5, 4'hF, 32'h0};
        vecs[8]  = '{0, 1, 32'h0000_0020, 32'h0BAD_F00D, 4'hF, 32'h0};
        vecs[9]  = '{1, 0, 32'h0000_0018, 32'h0,         4'h0, 32'h1234_5678};
        vecs[10] = '{0, 1, 32'h0000_0018, 32'hFFFF_FFFF, 4'hA, 32'h0};
        vecs[11] = '{1, 0, 32'h0000_0018, 32'h0,         4'h0, 32'hFF34_FF78};

        reset = 1'b1;
        inst_addr = '0;
        instruction = '0;
        for (int d = 0; d < 2; d++) begin
            address[d] = '0; writedata[d] = '0; byteenable[d] = '0;
            read[d] = 1'b0; write[d] = 1'b0; inst_input[d] = 1'b0; last_rd[d] = '0;
        end
        #1;
        check("rst_wait", {31'd0, waitrequest[0]}, 32'd0);
        check("rst_rdata", readdata[0], 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Program load then read through the aliased boot address.
        load_word(8'h04, 32'h2402_0010);
        xfer(0, 1, 0, 32'hBFC0_0004, 32'h0, 4'h0, 32'h2402_0010, 1 + WC);

        for (int i = 0; i < 12; i++)
            xfer(0, vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].be,
                 vecs[i].exp, 1 + WC);
        idle(0);

        // Back-to-back reads: each takes 1+WC stalls plus RESP, no gap between them.
        @(posedge clk); #1; t0 = cyc;
        xfer(0, 1, 0, 32'h04, 32'h0, 4'h0, 32'h2402_0010, 1 + WC);
        xfer(0, 1, 0, 32'h08, 32'h0, 4'h0, 32'h5A5A_A5A5, 1 + WC);
        #1;
        check("b2b_cycles", 32'(cyc - t0), 32'(2 * (2 + WC)));
        idle(0);

        // Read dropped during WAIT: back to idle, readdata untouched.
        @(negedge clk); address[0] = 32'h10; read[0] = 1'b1;
        @(negedge clk); read[0] = 1'b0;
        @(negedge clk); #1;
        check("abort_wait", {31'd0, waitrequest[0]}, 32'd0);
        check("abort_rdata", readdata[0], last_rd[0]);
        $display("xfer dut0 RD-ABORT addr=00000010 rdata=%h", readdata[0]);
        // Write dropped during WAIT must not commit.
        @(negedge clk); address[0] = 32'h10; writedata[0] = 32'h0; byteenable[0] = 4'hF; write[0] = 1'b1;
        @(negedge clk); write[0] = 1'b0;
        $display("xfer dut0 WR-ABORT addr=00000010");
        xfer(0, 1, 0, 32'h10, 32'h0, 4'h0, 32'hAA22_CC44, 1 + WC);
        idle(0);

        // Reset during a write's WAIT, with a load attempted while reset is held.
        @(negedge clk); address[0] = 32'h20; writedata[0] = 32'hDEAD_BEEF; byteenable[0] = 4'hF; write[0] = 1'b1;
        @(negedge clk); reset = 1'b1; write[0] = 1'b0;
        #1;
        check("rst_mid_wait", {31'd0, waitrequest[0]}, 32'd0);
        check("rst_mid_rdata", readdata[0], 32'd0);
        $display("xfer dut0 WR-RESET addr=00000020 rdata=%h", readdata[0]);
        last_rd[0] = 32'd0;
        inst_input[0] = 1'b1; inst_addr = 8'h20; instruction = 32'h7777_7777;
        repeat (2) @(negedge clk);
        inst_input[0] = 1'b0; reset = 1'b0;
        xfer(0, 1, 0, 32'h20, 32'h0, 4'h0, 32'h0BAD_F00D, 1 + WC);
        idle(0);

        // Bus read while a program load is active stalls until the load ends.
        @(negedge clk); inst_input[0] = 1'b1; inst_addr = 8'h08; instruction = 32'h1357_9BDF;
        fork
            xfer(0, 1, 0, 32'h08, 32'h0, 4'h0, 32'h1357_9BDF, 2 + 1 + WC);
            begin
                repeat (3) @(negedge clk);
                inst_input[0] = 1'b0;
            end
        join
        idle(0);

        // Zero-wait build: one stall cycle per transfer.
        xfer(1, 0, 1, 32'h30, 32'h0102_0304, 4'hF, 32'h0, 1);
        xfer(1, 1, 0, 32'h30, 32'h0, 4'h0, 32'h0102_0304, 1);
        xfer(1, 1, 0, 32'h30, 32'h0, 4'h0, 32'h0102_0304, 1);
        idle(1);

        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
